load_store_unit: RTL and testbench

- Sits between the single-cycle hart's data-memory port and a realistic latency-variable data memory.
- Replaces the current fixed word-wide combinational dmem access.
- Accepts one load/store request at a time from the hart and generates the aligned address, byte mask and lane-shifted write data.
- Runs a valid/ready plus read-valid handshake to memory, then returns sign/zero-extended load data or a trap flag.
- The hart stalls on o_req_ready/o_rsp_valid.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 33 +++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32I load/store funct3 codes, lane masks and memory request record.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RSP, DONE} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_req_t;
  function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
    return wen ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, write shift, read shift/extend and legality for one access.
// LSU_MISALIGN_CHECK_EN makes misaligned half/word accesses illegal instead of truncating the offset.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        wen,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);
  logic [1:0]  off;
  logic [31:0] rsh;
  always_comb begin
    off = funct3[1:0] == 2'b00 ? addr_lo : funct3[1:0] == 2'b01 ? {addr_lo[1], 1'b0} : 2'b00;
    mask = (funct3[1:0] == 2'b00 ? MASK_B : funct3[1:0] == 2'b01 ? MASK_H : MASK_W) << off;
    wdata_sh = wdata << {off, 3'b000};
    rsh = rdata >> {off, 3'b000};
    rdata_ext = funct3 == F3_B  ? {{24{rsh[7]}}, rsh[7:0]} :
                funct3 == F3_BU ? {24'b0, rsh[7:0]} :
                funct3 == F3_H  ? {{16{rsh[15]}}, rsh[15:0]} :
                funct3 == F3_HU ? {16'b0, rsh[15:0]} : rsh;
`ifdef LSU_MISALIGN_CHECK_EN
    legal = f3_legal(wen, funct3) && !((funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00));
`else
    legal = f3_legal(wen, funct3);
`endif
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LSU between the hart and a variable-latency data memory.
// Build option LSU_MISALIGN_CHECK_EN (in lsu_align) traps misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);
  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  lsu_state_e state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [1:0] addr_lo_q, addr_lo_d;
  logic [2:0] f3_q, f3_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_trap_q, rsp_trap_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  mem_req_t mem_q, mem_d;
  logic idle, legal, timeout;
  logic [3:0] mask;
  logic [31:0] wdata_sh, rdata_ext;
  assign idle = state_q == IDLE;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == T_LAST);
  // Alignment works on the live request while idle, on the latched fields afterwards.
  lsu_align u_align (
    .wen      (i_req_wen),
    .addr_lo  (idle ? i_req_addr[1:0] : addr_lo_q),
    .funct3   (idle ? i_req_funct3 : f3_q),
    .wdata    (i_req_wdata),
    .rdata    (i_mem_rdata),
    .legal    (legal),
    .mask     (mask),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext)
  );
  always_comb begin
    state_d = state_q;
    addr_lo_d = addr_lo_q;
    f3_d = f3_q;
    rsp_valid_d = 1'b0;
    rsp_trap_d = 1'b0;
    rsp_rdata_d = '0;
    mem_d = '0;
    case (state_q)
      IDLE: if (i_req_valid) begin
        addr_lo_d = i_req_addr[1:0];
        f3_d = i_req_funct3;
        state_d = legal ? MEM_REQ : DONE;
        rsp_valid_d = !legal;
        rsp_trap_d = !legal;
        mem_d = legal ? '{1'b1, {i_req_addr[31:2], 2'b00}, !i_req_wen, i_req_wen, wdata_sh, mask} : '0;
      end
      MEM_REQ: if (i_mem_ready) begin
        state_d = mem_q.wen ? DONE : MEM_RSP;
        rsp_valid_d = mem_q.wen;
      end else if (timeout) begin
        state_d = DONE;
        rsp_valid_d = 1'b1;
        rsp_trap_d = 1'b1;
      end else mem_d = mem_q;
      MEM_RSP: if (i_mem_rvalid || timeout) begin
        state_d = DONE;
        rsp_valid_d = 1'b1;
        rsp_trap_d = !i_mem_rvalid;
        rsp_rdata_d = i_mem_rvalid ? rdata_ext : '0;
      end
      DONE: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_lo_q <= '0;
      f3_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_trap_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_lo_q <= addr_lo_d;
      f3_q <= f3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_trap_q <= rsp_trap_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_q <= mem_d;
    end
  end
  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_trap = rsp_trap_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_mem_valid = mem_q.valid;
  assign o_mem_addr = mem_q.addr;
  assign o_mem_ren = mem_q.ren;
  assign o_mem_wen = mem_q.wen;
  assign o_mem_wdata = mem_q.wdata;
  assign o_mem_mask = mem_q.mask;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against an arithmetic reference model.
module tb_load_store_unit;
  localparam int T = 4;
  logic i_clk = 0, i_rst_n = 0;
  logic i_req_valid = 0, i_req_wen = 0, i_mem_ready = 0, i_mem_rvalid = 0;
  logic [31:0] i_req_addr = 0, i_req_wdata = 0, i_mem_rdata = 0;
  logic [2:0] i_req_funct3 = 0;
  logic o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_valid, o_mem_ren, o_mem_wen;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0] o_mem_mask;
  int checks = 0, errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T), .TIMER_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_funct3(i_req_funct3), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .o_mem_mask(o_mem_mask), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access of n bytes at an offset rounded down to a multiple of n.
  function automatic void model(input logic wen, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, input logic [31:0] rd, output bit legal,
                                output logic [3:0] m, output logic [31:0] wsh, output logic [31:0] rext);
    int n, off;
    longint v, lim;
    n = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
    legal = (f3[1:0] != 2'b11) && !(wen && f3[2]) && (f3 != 3'b110);
    off = int'(addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
    if (off % n != 0) legal = 0;
`endif
    off = off - off % n;
    m = 4'(((1 << n) - 1) << off);
    wsh = 32'(longint'(wd) << (8 * off));
    lim = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * off)) % lim;
    if (!f3[2] && n < 4 && v >= lim / 2) v = v - lim;
    rext = 32'(v);
  endfunction

  // dr: MEM_REQ cycles before ready; dv: MEM_RSP cycles before rvalid; junk: rvalid noise during MEM_REQ.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] rd, input int dr, input int dv, input bit junk);
    bit legal, to, hs;
    logic [3:0] m;
    logic [31:0] wsh, rext;
    int exp_lat, exp_nreq, nreq, lat, rsp_i;
    model(wen, addr, f3, wd, rd, legal, m, wsh, rext);
    to = legal && (dr >= T || (!wen && dv >= T));
    exp_nreq = !legal ? 0 : (dr < T ? dr + 1 : T);
    exp_lat = !legal ? 0 : dr >= T ? T : wen ? dr + 1 : dv >= T ? dr + 1 + T : dr + 2 + dv;
    @(negedge i_clk);
    check("req_ready", 32'(o_req_ready), 1);
    check("rsp_idle", 32'(o_rsp_valid), 0);
    i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_funct3 = f3; i_req_wdata = wd;
    @(posedge i_clk);
    #1;
    i_req_valid = 0; i_req_addr = $urandom; i_req_funct3 = 3'($urandom); i_req_wdata = $urandom;
    nreq = 0; hs = 0; rsp_i = 0; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge i_clk);
      i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = $urandom;
      if (o_rsp_valid) lat = k;
      else if (o_mem_valid) begin
        check("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
        check("mem_mask", 32'(o_mem_mask), 32'(m));
        check("mem_rw", 32'({o_mem_ren, o_mem_wen}), 32'({!wen, wen}));
        if (wen) check("mem_wdata", o_mem_wdata, wsh);
        i_mem_ready = (nreq == dr);
        i_mem_rvalid = junk;
        hs = (nreq == dr) && !wen;
        nreq++;
      end else if (hs) begin
        if (rsp_i == dv) begin i_mem_rvalid = 1; i_mem_rdata = rd; end
        rsp_i++;
      end
    end
    i_mem_ready = 0; i_mem_rvalid = 0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_cycles", 32'(nreq), 32'(exp_nreq));
    check("rsp_trap", 32'(o_rsp_trap), 32'(!legal || to));
    check("rsp_rdata", o_rsp_rdata, (legal && !to && !wen) ? rext : 32'h0);
    check("mem_quiet", {o_mem_valid, o_mem_ren, o_mem_wen, o_mem_mask} == 7'd0 ? o_mem_addr | o_mem_wdata : 32'hDEAD, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_valid, o_mem_ren, o_mem_wen, o_mem_mask}), 0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_wdata"}, o_mem_wdata, 0);
    check({tag, "_rdata"}, o_rsp_rdata, 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check_all_zero("reset");
    i_rst_n = 1;
    @(negedge i_clk);
    run_txn(1, 32'h2003, 3'b000, 32'h0000_00AB, 0, 0, 0, 0);
    run_txn(0, 32'h1001, 3'b000, 0, 32'h0000_F000, 0, 1, 0);
    run_txn(0, 32'h1001, 3'b100, 0, 32'h0000_F000, 0, 1, 0);
    run_txn(0, 32'h1002, 3'b001, 0, 32'h8000_0000, 1, 0, 1);
    run_txn(0, 32'h1002, 3'b101, 0, 32'h8000_0000, 0, 2, 0);
    run_txn(0, 32'h1000, 3'b011, 0, 32'h1234_5678, 0, 0, 0);
    run_txn(1, 32'h1000, 3'b100, 32'h55, 0, 0, 0, 0);
    run_txn(1, 32'h3000, 3'b010, 32'hCAFE_F00D, 0, 9, 0, 0);
    run_txn(0, 32'h3004, 3'b010, 0, 32'h1111_2222, 0, 9, 0);
    run_txn(0, 32'h3008, 3'b010, 0, 32'h3333_4444, T - 1, T - 1, 1);
    run_txn(0, 32'h1002, 3'b010, 0, 32'hA5A5_5A5A, 0, 0, 0);
    run_txn(1, 32'h1003, 3'b001, 32'h0000_BEEF, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++)
      run_txn(1'($urandom), $urandom, 3'($urandom), $urandom, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
    // Reset in the middle of a load response wait.
    @(negedge i_clk);
    i_req_valid = 1; i_req_wen = 0; i_req_addr = 32'h400; i_req_funct3 = 3'b010;
    @(posedge i_clk);
    #1 i_req_valid = 0;
    @(negedge i_clk);
    i_mem_ready = 1;
    @(negedge i_clk);
    i_mem_ready = 0;
    #2 i_rst_n = 0;
    #1 check_all_zero("rst_async");
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    check("ready_after_rst", 32'(o_req_ready), 1);
    i_mem_rvalid = 1; i_mem_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("late_rvalid", 32'({o_rsp_valid, o_rsp_trap, o_mem_valid}), 0);
      @(negedge i_clk);
    end
    run_txn(0, 32'h0000_0123, 3'b000, 0, 32'h7F80_0000, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
